reflet_float_add_arbiter: RTL and testbench

// Shares one combinational reflet_float_add instance between two requesters.

---
 rtl/reflet_float_add_arbiter.sv | 140 ++++++++++++++
 tb/tb_reflet_float_add_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reflet_float_add_arbiter.sv
// Two-requester front end for a single shared combinational float adder.
// Registers the chosen operand pair, lets the adder settle, then holds the tagged sum until acknowledged.
module reflet_float_add_arbiter #(
  parameter int float_size    = 32,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [float_size-1:0] req0_a,
  input  logic [float_size-1:0] req0_b,
  input  logic                  req0_sub,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [float_size-1:0] req1_a,
  input  logic [float_size-1:0] req1_b,
  input  logic                  req1_sub,
  output logic [float_size-1:0] fpu_in1,
  output logic [float_size-1:0] fpu_in2,
  input  logic [float_size-1:0] fpu_sum,
  output logic                  res_valid,
  output logic                  res_tag,
  output logic [float_size-1:0] res_data,
  input  logic                  res_ack
);

  localparam int CW = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYCLES - 1);
  localparam logic [float_size-1:0] SIGN_MASK = {1'b1, {(float_size-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OP   = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  last_grant_q, last_grant_d;
  logic [float_size-1:0] in1_q, in1_d;
  logic [float_size-1:0] in2_q, in2_d;
  logic [float_size-1:0] res_data_q, res_data_d;
  logic                  res_valid_q, res_valid_d;
  logic                  res_tag_q, res_tag_d;

  logic                  gnt0, gnt1;
  logic [float_size-1:0] sel_a, sel_b;
  logic                  sel_sub;

  // Round robin on a tie: last_grant resets to 1 so requester 0 wins first.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == IDLE && !reset) begin
      if (req0_valid && req1_valid) begin
        gnt0 = last_grant_q;
        gnt1 = !last_grant_q;
      end else begin
        gnt0 = req0_valid;
        gnt1 = req1_valid;
      end
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  assign sel_a   = gnt1 ? req1_a   : req0_a;
  assign sel_b   = gnt1 ? req1_b   : req0_b;
  assign sel_sub = gnt1 ? req1_sub : req0_sub;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    in1_d        = in1_q;
    in2_d        = in2_q;
    res_data_d   = res_data_q;
    res_valid_d  = res_valid_q;
    res_tag_d    = res_tag_q;
    case (state_q)
      IDLE: begin
        if (gnt0 || gnt1) begin
          in1_d        = sel_a;
          in2_d        = sel_sub ? (sel_b ^ SIGN_MASK) : sel_b;
          res_tag_d    = gnt1;
          last_grant_d = gnt1;
          cnt_d        = CNT_LOAD;
          state_d      = OP;
        end
      end
      OP: begin
        if (cnt_q == '0) begin
          res_data_d  = fpu_sum;
          res_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        if (res_ack) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      in1_q        <= '0;
      in2_q        <= '0;
      res_data_q   <= '0;
      res_valid_q  <= 1'b0;
      res_tag_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      in1_q        <= in1_d;
      in2_q        <= in2_d;
      res_data_q   <= res_data_d;
      res_valid_q  <= res_valid_d;
      res_tag_q    <= res_tag_d;
    end
  end

  assign fpu_in1   = in1_q;
  assign fpu_in2   = in2_q;
  assign res_data  = res_data_q;
  assign res_valid = res_valid_q;
  assign res_tag   = res_tag_q;

endmodule

// File: tb/tb_reflet_float_add_arbiter.sv
// Directed bench for reflet_float_add_arbiter: one instance with SETTLE_CYCLES=1, one with 4.
// A small lookup table stands in for the shared adder on the first instance.
module tb_reflet_float_add_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        r0v, r0r, r0s, r1v, r1r, r1s, res_ack, res_valid, res_tag;
  logic [31:0] r0a, r0b, r1a, r1b, fpu_in1, fpu_in2, fpu_sum, res_data;

  logic        s4_r0v, s4_r0r, s4_r1r, s4_res_valid, s4_res_tag;
  logic [31:0] s4_in1, s4_in2, s4_sum, s4_res_data, s4_r0a, s4_r0b;

  int checks   = 0;
  int failures = 0;

  reflet_float_add_arbiter #(.float_size(32), .SETTLE_CYCLES(1)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(r0v), .req0_ready(r0r), .req0_a(r0a), .req0_b(r0b), .req0_sub(r0s),
    .req1_valid(r1v), .req1_ready(r1r), .req1_a(r1a), .req1_b(r1b), .req1_sub(r1s),
    .fpu_in1(fpu_in1), .fpu_in2(fpu_in2), .fpu_sum(fpu_sum),
    .res_valid(res_valid), .res_tag(res_tag), .res_data(res_data), .res_ack(res_ack)
  );

  reflet_float_add_arbiter #(.float_size(32), .SETTLE_CYCLES(4)) dut4 (
    .clk(clk), .reset(reset),
    .req0_valid(s4_r0v), .req0_ready(s4_r0r), .req0_a(s4_r0a), .req0_b(s4_r0b), .req0_sub(1'b0),
    .req1_valid(1'b0), .req1_ready(s4_r1r), .req1_a(32'h0), .req1_b(32'h0), .req1_sub(1'b0),
    .fpu_in1(s4_in1), .fpu_in2(s4_in2), .fpu_sum(s4_sum),
    .res_valid(s4_res_valid), .res_tag(s4_res_tag), .res_data(s4_res_data), .res_ack(1'b0)
  );

  // Adder stand-in: only the operand pairs used here have real sums.
  always_comb begin
    fpu_sum = 32'hDEAD_BEEF;
    if (fpu_in1 == 32'h40A0_0000 && fpu_in2 == 32'h4170_0000) fpu_sum = 32'h41A0_0000;
    if (fpu_in1 == 32'h40A0_0000 && fpu_in2 == 32'hC170_0000) fpu_sum = 32'hC120_0000;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_res();
    int n = 0;
    while (!res_valid && n < 20) begin
      step();
      n++;
    end
    chk("res_valid_seen", {31'b0, res_valid}, 32'd1);
  endtask

  // Both requesters held valid; expect the grant to go to exp_tag, then ack at once.
  task automatic run_both(input logic exp_tag);
    int n = 0;
    #1;
    while (!(r0r || r1r) && n < 20) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("ready_exclusive", {31'b0, r0r & r1r}, 32'd0);
    chk("grant_who", {30'b0, r1r, r0r}, exp_tag ? 32'd2 : 32'd1);
    step();
    wait_res();
    chk("rr_tag", {31'b0, res_tag}, {31'b0, exp_tag});
    chk("rr_data", res_data, 32'h41A0_0000);
    res_ack = 1'b1;
    step();
    res_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    r0v = 0; r0a = 0; r0b = 0; r0s = 0;
    r1v = 0; r1a = 0; r1b = 0; r1s = 0;
    res_ack = 0;
    s4_r0v = 0; s4_r0a = 0; s4_r0b = 0; s4_sum = 0;
    #2;
    r0v = 1'b1;
    #1;
    chk("rst_res_valid", {31'b0, res_valid}, 32'd0);
    chk("rst_res_data", res_data, 32'd0);
    chk("rst_fpu_in1", fpu_in1, 32'd0);
    chk("rst_fpu_in2", fpu_in2, 32'd0);
    chk("rst_ready0", {31'b0, r0r}, 32'd0);
    r0v = 1'b0;
    #9;
    reset = 1'b0;
    step();

    // req0 add 5.0 + 15.0
    r0v = 1; r0a = 32'h40A0_0000; r0b = 32'h4170_0000; r0s = 0;
    #1;
    chk("t1_ready0", {31'b0, r0r}, 32'd1);
    chk("t1_ready1", {31'b0, r1r}, 32'd0);
    step();
    chk("t1_in1", fpu_in1, 32'h40A0_0000);
    chk("t1_in2", fpu_in2, 32'h4170_0000);
    chk("t1_op_no_res", {31'b0, res_valid}, 32'd0);
    chk("t1_op_no_ready", {31'b0, r0r}, 32'd0);
    r0a = 32'h1234_5678;
    step();
    chk("t1_res_valid", {31'b0, res_valid}, 32'd1);
    chk("t1_res_data", res_data, 32'h41A0_0000);
    chk("t1_res_tag", {31'b0, res_tag}, 32'd0);
    chk("t1_in1_held", fpu_in1, 32'h40A0_0000);
    r0v = 0; res_ack = 1;
    step();
    res_ack = 0;
    chk("t1_ack_clears", {31'b0, res_valid}, 32'd0);

    // req1 sub 5.0 - 15.0
    r1v = 1; r1a = 32'h40A0_0000; r1b = 32'h4170_0000; r1s = 1;
    #1;
    chk("t2_ready1", {31'b0, r1r}, 32'd1);
    chk("t2_ready0", {31'b0, r0r}, 32'd0);
    step();
    r1v = 0;
    chk("t2_in2_flip", fpu_in2, 32'hC170_0000);
    step();
    chk("t2_res_valid", {31'b0, res_valid}, 32'd1);
    chk("t2_res_data", res_data, 32'hC120_0000);
    chk("t2_res_tag", {31'b0, res_tag}, 32'd1);
    res_ack = 1;
    step();
    res_ack = 0;

    // continuous tie alternates
    r0v = 1; r0a = 32'h40A0_0000; r0b = 32'h4170_0000; r0s = 0;
    r1v = 1; r1a = 32'h40A0_0000; r1b = 32'h4170_0000; r1s = 0;
    run_both(1'b0);
    run_both(1'b1);
    run_both(1'b0);
    run_both(1'b1);

    // ack held off for 10 cycles with both requesters pending
    #1;
    chk("t4_grant0", {30'b0, r1r, r0r}, 32'd1);
    step();
    step();
    for (int i = 0; i < 10; i++) begin
      chk("t4_hold_valid", {31'b0, res_valid}, 32'd1);
      chk("t4_hold_data", res_data, 32'h41A0_0000);
      chk("t4_hold_in1", fpu_in1, 32'h40A0_0000);
      chk("t4_hold_noready", {31'b0, r0r | r1r}, 32'd0);
      step();
    end
    res_ack = 1;
    step();
    res_ack = 0;
    #1;
    chk("t4_next_grant1", {30'b0, r1r, r0r}, 32'd2);
    chk("t4_valid_low", {31'b0, res_valid}, 32'd0);
    step();
    step();
    chk("t4_tag1", {31'b0, res_tag}, 32'd1);
    r0v = 0; r1v = 0; res_ack = 1;
    step();
    step();
    chk("t5_stray_ack", {31'b0, res_valid}, 32'd0);
    res_ack = 0;

    // reset during OP (req1 in flight)
    r1v = 1; r1s = 1;
    step();
    r1v = 0;
    #1;
    reset = 1;
    #1;
    chk("rop_valid", {31'b0, res_valid}, 32'd0);
    chk("rop_in1", fpu_in1, 32'd0);
    chk("rop_in2", fpu_in2, 32'd0);
    chk("rop_tag", {31'b0, res_tag}, 32'd0);
    #3;
    reset = 0;
    step();
    step();
    step();
    chk("rop_no_result", {31'b0, res_valid}, 32'd0);

    // reset during DONE after a req0 grant
    r0v = 1;
    step();
    r0v = 0;
    wait_res();
    #2;
    reset = 1;
    #1;
    chk("rdone_valid", {31'b0, res_valid}, 32'd0);
    chk("rdone_data", res_data, 32'd0);
    chk("rdone_in1", fpu_in1, 32'd0);
    #3;
    reset = 0;
    step();
    r0v = 1; r1v = 1;
    #1;
    chk("rdone_tie_req0", {30'b0, r1r, r0r}, 32'd1);
    r0v = 0; r1v = 0;

    // SETTLE_CYCLES=4 latency and final-value capture
    #1;
    reset = 1;
    #2;
    reset = 0;
    step();
    s4_r0v = 1; s4_r0a = 32'h3F80_0000; s4_r0b = 32'h4000_0000; s4_sum = 32'h1111_1111;
    #1;
    chk("s4_ready", {31'b0, s4_r0r}, 32'd1);
    step();
    s4_r0v = 0;
    for (int i = 0; i < 4; i++) begin
      chk("s4_not_yet", {31'b0, s4_res_valid}, 32'd0);
      s4_sum = (i == 3) ? 32'h3333_3333 : (32'h1000_0000 * (i + 2));
      step();
    end
    chk("s4_valid", {31'b0, s4_res_valid}, 32'd1);
    chk("s4_data", s4_res_data, 32'h3333_3333);
    chk("s4_in2", s4_in2, 32'h4000_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
